// File: rtl/rvc_aligner.sv
// Fetch-to-decode realigner: buffers word-aligned fetch words and emits
// in-order 16-bit (RVC) and 32-bit instructions with their PC.
module rvc_aligner #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        s_clk_i,
   input  logic        s_resetn_i,
   input  logic        s_flush_i,
   input  logic [31:0] s_flush_addr_i,
   input  logic        s_fetch_val_i,
   input  logic [31:0] s_fetch_data_i,
   input  logic        s_fetch_err_i,
   output logic        s_fetch_rdy_o,
   output logic        s_ins_val_o,
   output logic [31:0] s_ins_data_o,
   output logic        s_ins_rvc_o,
   output logic [31:0] s_ins_addr_o,
   output logic        s_ins_err_o,
   input  logic        s_ins_rdy_i
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [31:0] RST_PC = RESET_PC & 32'hFFFF_FFFE;

   logic [31:0]   fifo_data [DEPTH];
   logic          fifo_err  [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic [15:0]   hw_q;
   logic          hw_err;
   logic          hw_v;
   logic          drop_low;
   logic [31:0]   pc_q;

   logic          head_v;
   logic          full;
   logic [31:0]   head_data;
   logic          head_err;
   logic          push;
   logic          pop;
   logic          hw_ld;
   logic          hw_done;
   logic          drop_done;
   logic          ins_val;
   logic [31:0]   ins_raw;
   logic          ins_rvc;
   logic          ins_err;
   logic          hs;

   assign head_v    = (count != '0);
   assign full      = (count == CW'(DEPTH));
   assign head_data = fifo_data[rd_ptr];
   assign head_err  = fifo_err[rd_ptr];
   assign push      = s_fetch_val_i & ~full;
   assign hs        = ins_val & s_ins_rdy_i;

   assign s_fetch_rdy_o = ~full;
   assign s_ins_val_o   = ins_val;
   assign s_ins_data_o  = ins_err ? 32'h0 : ins_raw;
   assign s_ins_rvc_o   = ins_rvc & ~ins_err;
   assign s_ins_err_o   = ins_err;
   assign s_ins_addr_o  = pc_q;

   // Select the next instruction from the held halfword and FIFO head
   always_comb begin
      pop       = 1'b0;
      hw_ld     = 1'b0;
      hw_done   = 1'b0;
      drop_done = 1'b0;
      ins_val   = 1'b0;
      ins_raw   = 32'h0;
      ins_rvc   = 1'b0;
      ins_err   = 1'b0;
      if (drop_low) begin
         // Entered mid-word: discard the low halfword, keep the high one
         if (head_v) begin
            pop       = 1'b1;
            hw_ld     = 1'b1;
            drop_done = 1'b1;
         end
      end else if (!hw_v) begin
         if (head_v) begin
            ins_val = 1'b1;
            ins_err = head_err;
            if (head_data[1:0] != 2'b11) begin
               ins_rvc = 1'b1;
               ins_raw = {16'h0, head_data[15:0]};
               pop     = s_ins_rdy_i;
               hw_ld   = s_ins_rdy_i;
            end else begin
               ins_raw = head_data;
               pop     = s_ins_rdy_i;
            end
         end
      end else if (hw_q[1:0] != 2'b11) begin
         ins_val = 1'b1;
         ins_rvc = 1'b1;
         ins_raw = {16'h0, hw_q};
         ins_err = hw_err;
         hw_done = s_ins_rdy_i;
      end else if (head_v) begin
         // 32-bit instruction straddling two fetch words
         ins_val = 1'b1;
         ins_raw = {head_data[15:0], hw_q};
         ins_err = hw_err | head_err;
         pop     = s_ins_rdy_i;
         hw_ld   = s_ins_rdy_i;
      end
   end

   // FIFO storage write (payload only, pointers reset separately)
   always_ff @(posedge s_clk_i) begin
      if (push && !s_flush_i) begin
         fifo_data[wr_ptr] <= s_fetch_data_i;
         fifo_err[wr_ptr]  <= s_fetch_err_i;
      end
   end

   // Pointers, halfword buffer, alignment flag and PC
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         hw_q     <= 16'h0;
         hw_err   <= 1'b0;
         hw_v     <= 1'b0;
         drop_low <= RESET_PC[1];
         pc_q     <= RST_PC;
      end else if (s_flush_i) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         hw_err   <= 1'b0;
         hw_v     <= 1'b0;
         drop_low <= s_flush_addr_i[1];
         pc_q     <= s_flush_addr_i & 32'hFFFF_FFFE;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
         if (hw_ld) begin
            hw_q   <= head_data[31:16];
            hw_err <= head_err;
            hw_v   <= 1'b1;
         end else if (hw_done) begin
            hw_v   <= 1'b0;
         end
         if (drop_done) drop_low <= 1'b0;
         if (hs) pc_q <= pc_q + (ins_rvc ? 32'd2 : 32'd4);
      end
   end

endmodule
